// File: rtl/vid_seq.sv
// vid_seq: breaks one vid.v request into per-beat issues and tracks results in flight.
// Optional VID_SEQ_ABORT_EN adds req_abort to stop issue early.
module vid_seq #(
  parameter int unsigned REQ_BYTE_EN_WIDTH = 8,
  parameter int unsigned REQ_ADDR_WIDTH    = 32,
  parameter int unsigned VL_WIDTH          = 9,
  parameter int unsigned PIPE_LAT          = 6
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [VL_WIDTH-1:0]          req_vl,
  input  logic [2:0]                   req_sew,
  input  logic [REQ_ADDR_WIDTH-1:0]    req_addr,
  output logic                         vid_valid,
  output logic [2:0]                   vid_sew,
  output logic [7:0]                   vid_start_idx,
  output logic [REQ_BYTE_EN_WIDTH-1:0] vid_mask,
  output logic [REQ_ADDR_WIDTH-1:0]    vid_addr,
  input  logic                         vid_resp_valid,
  output logic                         busy,
  output logic                         done,
  output logic                         req_err
`ifdef VID_SEQ_ABORT_EN
  ,
  input  logic                         req_abort
`endif
);

  localparam int unsigned CNT_W = $clog2(PIPE_LAT + 1) + 1;
  localparam int unsigned EW    = VL_WIDTH + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t                      state_q, state_d;
  logic [VL_WIDTH-1:0]         vl_q, vl_d;
  logic [REQ_ADDR_WIDTH-1:0]   base_q, base_d;
  logic [VL_WIDTH-1:0]         elem_q, elem_d;
  logic [VL_WIDTH-1:0]         beat_q, beat_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic [2:0]                  sew_d;
  logic                        valid_d, busy_d, done_d, err_d;
  logic [7:0]                  idx_d;
  logic [REQ_BYTE_EN_WIDTH-1:0] mask_d;
  logic [REQ_ADDR_WIDTH-1:0]   addr_d;
  logic [VL_WIDTH-1:0]         epb_q, epb_d, rem, take;
  logic [EW-1:0]               elem_sum;
  logic                        inc, dec, abort_c;

`ifdef VID_SEQ_ABORT_EN
  assign abort_c = req_abort;
`else
  assign abort_c = 1'b0;
`endif

  assign req_ready = (state_q == IDLE);

  // Next-state, counters and next values of the registered outputs.
  always_comb begin
    state_d  = state_q;
    vl_d     = vl_q;
    sew_d    = vid_sew;
    base_d   = base_q;
    elem_d   = elem_q;
    beat_d   = beat_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    valid_d  = 1'b0;
    busy_d   = 1'b0;
    idx_d    = '0;
    mask_d   = '0;
    addr_d   = '0;
    epb_q    = VL_WIDTH'(REQ_BYTE_EN_WIDTH) >> vid_sew;
    elem_sum = {1'b0, elem_q} + {1'b0, epb_q};
    inc      = vid_valid;
    dec      = vid_resp_valid && (cnt_q != '0);

    case ({inc, dec})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          vl_d   = req_vl;
          sew_d  = req_sew;
          base_d = req_addr;
          elem_d = '0;
          beat_d = '0;
          cnt_d  = '0;
          if (req_sew > 3'd3) begin
            err_d  = 1'b1;
            done_d = 1'b1;
          end else if (req_vl == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        elem_d = elem_sum[VL_WIDTH-1:0];
        beat_d = beat_q + VL_WIDTH'(1);
        // The sum is one bit wider so a large vl cannot wrap past the end test.
        if ((elem_sum >= {1'b0, vl_q}) || abort_c) state_d = DRAIN;
      end
      DRAIN: begin
        if (cnt_d == '0) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Beat fields are built from the values that will be current next cycle.
    epb_d   = VL_WIDTH'(REQ_BYTE_EN_WIDTH) >> sew_d;
    rem     = vl_d - elem_d;
    take    = (rem < epb_d) ? rem : epb_d;
    valid_d = (state_d == ISSUE);
    busy_d  = (state_d != IDLE);
    if (valid_d) begin
      idx_d  = elem_d[7:0];
      addr_d = base_d + REQ_ADDR_WIDTH'(beat_d);
      for (int unsigned i = 0; i < REQ_BYTE_EN_WIDTH; i++) begin
        mask_d[i] = (VL_WIDTH'(i) < take);
      end
    end
  end

  // State, counters and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      vl_q          <= '0;
      base_q        <= '0;
      elem_q        <= '0;
      beat_q        <= '0;
      cnt_q         <= '0;
      vid_valid     <= 1'b0;
      vid_sew       <= '0;
      vid_start_idx <= '0;
      vid_mask      <= '0;
      vid_addr      <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      req_err       <= 1'b0;
    end else begin
      state_q       <= state_d;
      vl_q          <= vl_d;
      base_q        <= base_d;
      elem_q        <= elem_d;
      beat_q        <= beat_d;
      cnt_q         <= cnt_d;
      vid_valid     <= valid_d;
      vid_sew       <= sew_d;
      vid_start_idx <= idx_d;
      vid_mask      <= mask_d;
      vid_addr      <= addr_d;
      busy          <= busy_d;
      done          <= done_d;
      req_err       <= err_d;
    end
  end

endmodule

// File: tb/tb_vid_seq.sv
// Self-checking bench for vid_seq: directed scenarios plus randomized requests against a beat-list model.
// Build with VID_SEQ_ABORT_EN defined to also exercise req_abort.
module tb_vid_seq;

  localparam int unsigned BEW = 8;
  localparam int unsigned AW  = 32;
  localparam int unsigned VW  = 9;
  localparam int unsigned LAT = 6;

  logic           clk;
  logic           rst;
  logic           req_valid;
  logic           req_ready;
  logic [VW-1:0]  req_vl;
  logic [2:0]     req_sew;
  logic [AW-1:0]  req_addr;
  logic           vid_valid;
  logic [2:0]     vid_sew;
  logic [7:0]     vid_start_idx;
  logic [BEW-1:0] vid_mask;
  logic [AW-1:0]  vid_addr;
  logic           vid_resp_valid;
  logic           busy;
  logic           done;
  logic           req_err;
`ifdef VID_SEQ_ABORT_EN
  logic           req_abort;
`endif

  vid_seq #(.REQ_BYTE_EN_WIDTH(BEW), .REQ_ADDR_WIDTH(AW), .VL_WIDTH(VW), .PIPE_LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_vl(req_vl), .req_sew(req_sew), .req_addr(req_addr),
    .vid_valid(vid_valid), .vid_sew(vid_sew), .vid_start_idx(vid_start_idx), .vid_mask(vid_mask),
    .vid_addr(vid_addr), .vid_resp_valid(vid_resp_valid), .busy(busy), .done(done), .req_err(req_err)
`ifdef VID_SEQ_ABORT_EN
    , .req_abort(req_abort)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Fixed-latency datapath stand-in, reset together with the sequencer.
  logic [LAT-1:0] pipe;
  always @(posedge clk) begin
    if (rst) pipe <= '0;
    else     pipe <= {pipe[LAT-2:0], vid_valid};
  end
  assign vid_resp_valid = pipe[LAT-1];

  int errors = 0;
  int checks = 0;

  int             obs_off[$];
  logic [7:0]     obs_idx[$];
  logic [BEW-1:0] obs_mask[$];
  logic [AW-1:0]  obs_addr[$];
  logic [2:0]     obs_sew[$];
  int             done_off, err_off, busy_hi;
  logic           ready_at_done;
  int             abort_at = 0;

  int             exp_off[$];
  logic [7:0]     exp_idx[$];
  logic [BEW-1:0] exp_mask[$];
  logic [AW-1:0]  exp_addr[$];
  int             exp_done, exp_err, exp_busy;

  // Reference: list of beats a request should produce, straight from the arithmetic rules.
  task automatic model(input int vl, input int sew, input logic [AW-1:0] addr, input int abort_off);
    int epb, n, cnt;
    exp_off.delete(); exp_idx.delete(); exp_mask.delete(); exp_addr.delete();
    exp_err = -1;
    if (sew > 3) begin
      exp_done = 1; exp_err = 1; exp_busy = 0;
    end else if (vl == 0) begin
      exp_done = 1; exp_busy = 0;
    end else begin
      epb = BEW >> sew;
      n = (vl + epb - 1) / epb;
      if (abort_off > 0 && abort_off < n) n = abort_off;
      for (int b = 0; b < n; b++) begin
        cnt = vl - b * epb;
        if (cnt > epb) cnt = epb;
        exp_off.push_back(b + 1);
        exp_idx.push_back(8'((b * epb) % 256));
        exp_mask.push_back(BEW'((1 << cnt) - 1));
        exp_addr.push_back(addr + AW'(b));
      end
      exp_done = n + LAT + 1;
      exp_busy = exp_done - 1;
    end
  endtask

  // Offer one request and record everything seen up to and including the done cycle.
  task automatic send(input int vl, input int sew, input logic [AW-1:0] addr, input bit b2b);
    obs_off.delete(); obs_idx.delete(); obs_mask.delete(); obs_addr.delete(); obs_sew.delete();
    done_off = -1; err_off = -1; busy_hi = 0; ready_at_done = 1'b0;
    if (!b2b) @(negedge clk);
    req_valid = 1'b1; req_vl = VW'(vl); req_sew = 3'(sew); req_addr = addr;
    @(negedge clk);
    req_valid = 1'b0;
    for (int k = 1; k <= 600; k++) begin
`ifdef VID_SEQ_ABORT_EN
      req_abort = (k == abort_at);
`endif
      if (vid_valid) begin
        obs_off.push_back(k); obs_idx.push_back(vid_start_idx); obs_mask.push_back(vid_mask);
        obs_addr.push_back(vid_addr); obs_sew.push_back(vid_sew);
      end
      if (req_err && err_off < 0) err_off = k;
      if (busy) busy_hi++;
      if (done) begin
        done_off = k; ready_at_done = req_ready;
        break;
      end
      @(negedge clk);
    end
`ifdef VID_SEQ_ABORT_EN
    req_abort = 1'b0;
`endif
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; req_vl = '0; req_sew = '0; req_addr = '0;
`ifdef VID_SEQ_ABORT_EN
    req_abort = 1'b0;
`endif
    repeat (3) @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", req_ready); end
    checks++; if (vid_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", vid_valid); end
    checks++; if (vid_sew !== 3'd0) begin errors++; $display("FAIL reset_sew got %0d want 0", vid_sew); end
    checks++; if ({vid_start_idx, vid_mask} !== 16'h0) begin errors++; $display("FAIL reset_idx_mask got %h want 0", {vid_start_idx, vid_mask}); end
    checks++; if (vid_addr !== 32'h0) begin errors++; $display("FAIL reset_addr got %h want 0", vid_addr); end
    checks++; if ({busy, done, req_err} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b want 000", {busy, done, req_err}); end
    rst = 1'b0;
  endtask

  task automatic test_single_beat();
    send(8, 0, 32'h100, 1'b0);
    checks++; if (obs_off.size() != 1) begin errors++; $display("FAIL single_nbeats got %0d want 1", obs_off.size()); end
    if (obs_off.size() > 0) begin
      checks++; if (obs_off[0] != 1) begin errors++; $display("FAIL single_first_cycle got T+%0d want T+1", obs_off[0]); end
      checks++; if (obs_idx[0] !== 8'd0) begin errors++; $display("FAIL single_idx got %0d want 0", obs_idx[0]); end
      checks++; if (obs_mask[0] !== 8'hFF) begin errors++; $display("FAIL single_mask got %h want ff", obs_mask[0]); end
      checks++; if (obs_addr[0] !== 32'h100) begin errors++; $display("FAIL single_addr got %h want 100", obs_addr[0]); end
    end
    checks++; if (done_off != 8) begin errors++; $display("FAIL single_done got T+%0d want T+8", done_off); end
    checks++; if (busy_hi != 7) begin errors++; $display("FAIL single_busy_cycles got %0d want 7", busy_hi); end
    checks++; if (err_off != -1) begin errors++; $display("FAIL single_err got %0d want none", err_off); end
    checks++; if (ready_at_done !== 1'b1) begin errors++; $display("FAIL single_ready_at_done got %b want 1", ready_at_done); end
  endtask

  task automatic test_multi_beat();
    logic [AW-1:0] base;
    base = 32'h0000_2000;
    send(13, 1, base, 1'b0);
    checks++; if (obs_off.size() != 4) begin errors++; $display("FAIL multi_nbeats got %0d want 4", obs_off.size()); end
    for (int i = 0; i < 4 && i < obs_off.size(); i++) begin
      checks++;
      if (obs_off[i] != i + 1 || obs_idx[i] !== 8'(4 * i) || obs_mask[i] !== ((i == 3) ? 8'h01 : 8'h0F) ||
          obs_addr[i] !== base + AW'(i) || obs_sew[i] !== 3'd1) begin
        errors++;
        $display("FAIL multi_beat%0d got cyc=%0d idx=%0d mask=%h addr=%h sew=%0d want cyc=%0d idx=%0d mask=%h addr=%h sew=1",
                 i, obs_off[i], obs_idx[i], obs_mask[i], obs_addr[i], obs_sew[i],
                 i + 1, 4 * i, (i == 3) ? 8'h01 : 8'h0F, base + AW'(i));
      end
    end
    checks++; if (done_off != 11) begin errors++; $display("FAIL multi_done got T+%0d want T+11", done_off); end
  endtask

  task automatic test_trivial();
    send(0, 2, 32'h40, 1'b0);
    checks++; if (obs_off.size() != 0) begin errors++; $display("FAIL vl0_nbeats got %0d want 0", obs_off.size()); end
    checks++; if (done_off != 1) begin errors++; $display("FAIL vl0_done got T+%0d want T+1", done_off); end
    checks++; if (err_off != -1) begin errors++; $display("FAIL vl0_err got %0d want none", err_off); end
    checks++; if (busy_hi != 0 || ready_at_done !== 1'b1) begin errors++; $display("FAIL vl0_busy_ready got busy=%0d ready=%b want 0 1", busy_hi, ready_at_done); end
    send(20, 5, 32'h80, 1'b0);
    checks++; if (obs_off.size() != 0) begin errors++; $display("FAIL sew5_nbeats got %0d want 0", obs_off.size()); end
    checks++; if (done_off != 1) begin errors++; $display("FAIL sew5_done got T+%0d want T+1", done_off); end
    checks++; if (err_off != 1) begin errors++; $display("FAIL sew5_err got %0d want T+1", err_off); end
    @(negedge clk);
    checks++; if (req_err !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL sew5_pulse_len got err=%b done=%b want 0 0", req_err, done); end
  endtask

  task automatic test_max_vl();
    int wrap_bad;
    send(256, 3, 32'hFFFF_FF00, 1'b0);
    checks++; if (obs_off.size() != 256) begin errors++; $display("FAIL maxvl_nbeats got %0d want 256", obs_off.size()); end
    wrap_bad = 0;
    for (int i = 0; i < obs_idx.size(); i++) if (obs_idx[i] !== 8'(i) || obs_off[i] != i + 1) wrap_bad++;
    checks++; if (wrap_bad != 0) begin errors++; $display("FAIL maxvl_idx_sequence got %0d bad beats want 0", wrap_bad); end
    if (obs_off.size() > 0) begin
      checks++; if (obs_idx[$] !== 8'd255 || obs_mask[$] !== 8'h01) begin errors++; $display("FAIL maxvl_last got idx=%0d mask=%h want 255 01", obs_idx[$], obs_mask[$]); end
      checks++; if (obs_addr[$] !== 32'hFFFF_FF00 + 32'd255) begin errors++; $display("FAIL maxvl_last_addr got %h want %h", obs_addr[$], 32'hFFFF_FF00 + 32'd255); end
    end
    checks++; if (done_off != 263) begin errors++; $display("FAIL maxvl_done got T+%0d want T+263", done_off); end
  endtask

  task automatic test_reset_mid();
    int stray;
    @(negedge clk);
    req_valid = 1'b1; req_vl = 9'd40; req_sew = 3'd0; req_addr = 32'h500;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (vid_valid !== 1'b1 || vid_start_idx !== 8'd16) begin errors++; $display("FAIL rstmid_beat3 got valid=%b idx=%0d want 1 16", vid_valid, vid_start_idx); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (vid_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL rstmid_after got valid=%b busy=%b ready=%b want 0 0 1", vid_valid, busy, req_ready); end
    rst = 1'b0;
    stray = 0;
    repeat (10) begin
      @(negedge clk);
      if (vid_valid || done || busy) stray++;
    end
    checks++; if (stray != 0) begin errors++; $display("FAIL rstmid_quiet got %0d active cycles want 0", stray); end
    model(13, 1, 32'h600, 0);
    send(13, 1, 32'h600, 1'b0);
    checks++; if (obs_off.size() != exp_off.size()) begin errors++; $display("FAIL rstmid_nbeats got %0d want %0d", obs_off.size(), exp_off.size()); end
    for (int i = 0; i < exp_off.size() && i < obs_off.size(); i++) begin
      checks++;
      if (obs_off[i] != exp_off[i] || obs_idx[i] !== exp_idx[i] || obs_mask[i] !== exp_mask[i] || obs_addr[i] !== exp_addr[i]) begin
        errors++;
        $display("FAIL rstmid_beat%0d got cyc=%0d idx=%0d mask=%h addr=%h want cyc=%0d idx=%0d mask=%h addr=%h",
                 i, obs_off[i], obs_idx[i], obs_mask[i], obs_addr[i], exp_off[i], exp_idx[i], exp_mask[i], exp_addr[i]);
      end
    end
    checks++; if (done_off != exp_done) begin errors++; $display("FAIL rstmid_done got T+%0d want T+%0d", done_off, exp_done); end
  endtask

`ifdef VID_SEQ_ABORT_EN
  task automatic test_abort();
    abort_at = 2;
    send(32, 0, 32'h900, 1'b0);
    abort_at = 0;
    checks++; if (obs_off.size() != 2) begin errors++; $display("FAIL abort_nbeats got %0d want 2", obs_off.size()); end
    checks++; if (done_off != 9) begin errors++; $display("FAIL abort_done got T+%0d want T+9", done_off); end
  endtask
`endif

  // Random requests, sometimes offered in the done cycle of the previous one.
  task automatic test_random();
    int vl, sew;
    logic [AW-1:0] addr;
    bit b2b;
    for (int r = 0; r < 24; r++) begin
      vl   = int'($urandom_range(0, 256));
      sew  = int'($urandom_range(0, 4));
      if (sew == 4) sew = int'($urandom_range(4, 7));
      if ($urandom_range(0, 7) == 0) vl = 0;
      addr = $urandom;
      b2b  = 1'($urandom_range(0, 1));
`ifdef VID_SEQ_ABORT_EN
      abort_at = int'($urandom_range(0, 5));
`endif
      model(vl, sew, addr, abort_at);
      send(vl, sew, addr, b2b);
      abort_at = 0;
      checks++; if (obs_off.size() != exp_off.size()) begin errors++; $display("FAIL rand%0d_nbeats vl=%0d sew=%0d got %0d want %0d", r, vl, sew, obs_off.size(), exp_off.size()); end
      for (int i = 0; i < exp_off.size() && i < obs_off.size(); i++) begin
        checks++;
        if (obs_off[i] != exp_off[i] || obs_idx[i] !== exp_idx[i] || obs_mask[i] !== exp_mask[i] ||
            obs_addr[i] !== exp_addr[i] || obs_sew[i] !== 3'(sew)) begin
          errors++;
          $display("FAIL rand%0d_beat%0d got cyc=%0d idx=%0d mask=%h addr=%h sew=%0d want cyc=%0d idx=%0d mask=%h addr=%h sew=%0d",
                   r, i, obs_off[i], obs_idx[i], obs_mask[i], obs_addr[i], obs_sew[i],
                   exp_off[i], exp_idx[i], exp_mask[i], exp_addr[i], sew);
        end
      end
      checks++; if (done_off != exp_done) begin errors++; $display("FAIL rand%0d_done got T+%0d want T+%0d", r, done_off, exp_done); end
      checks++; if (err_off != exp_err) begin errors++; $display("FAIL rand%0d_err got %0d want %0d", r, err_off, exp_err); end
      checks++; if (busy_hi != exp_busy) begin errors++; $display("FAIL rand%0d_busy got %0d want %0d", r, busy_hi, exp_busy); end
      checks++; if (ready_at_done !== 1'b1) begin errors++; $display("FAIL rand%0d_ready got %b want 1", r, ready_at_done); end
    end
  endtask

  // Second request offered in the very cycle done is high.
  task automatic test_back_to_back();
    send(5, 2, 32'hA00, 1'b0);
    model(9, 3, 32'hB00, 0);
    send(9, 3, 32'hB00, 1'b1);
    checks++; if (obs_off.size() != exp_off.size()) begin errors++; $display("FAIL b2b_nbeats got %0d want %0d", obs_off.size(), exp_off.size()); end
    if (obs_off.size() > 0) begin
      checks++; if (obs_off[0] != 1 || obs_addr[0] !== 32'hB00) begin errors++; $display("FAIL b2b_first got cyc=%0d addr=%h want 1 b00", obs_off[0], obs_addr[0]); end
    end
    checks++; if (done_off != exp_done) begin errors++; $display("FAIL b2b_done got T+%0d want T+%0d", done_off, exp_done); end
  endtask

  initial begin
    test_reset();
    test_single_beat();
    test_multi_beat();
    test_trivial();
    test_max_vl();
    test_reset_mid();
`ifdef VID_SEQ_ABORT_EN
    test_abort();
`endif
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vid_seq.md
# vid_seq

Sequencer for the vector index-generation (vid.v) datapath in the vALU. It accepts one vid instruction at a time (vl, SEW, destination base address) and breaks it into per-beat issues. Each beat carries a start index, a byte-enable mask and an address. It counts beats in flight through the fixed-latency index pipeline and pulses `done` when the last result has retired. Only one instruction is in flight; the next is accepted only after `done`.

## Interface
Parameters:
- REQ_BYTE_EN_WIDTH, 8, bytes per beat; elements per beat = REQ_BYTE_EN_WIDTH >> sew
- REQ_ADDR_WIDTH, 32, destination address width
- VL_WIDTH, 9, vector-length width (max vl 256)
- PIPE_LAT, 6, datapath latency from issue to `vid_resp_valid`; sizes the in-flight counter

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- req_valid  in  1  instruction offered
- req_ready  out  1  high only in IDLE
- req_vl  in  VL_WIDTH  element count
- req_sew  in  3  element width code; 0..3 legal
- req_addr  in  REQ_ADDR_WIDTH  destination base address
- vid_valid  out  1  beat issue to datapath
- vid_sew  out  3  latched SEW
- vid_start_idx  out  8  index of first element in beat
- vid_mask  out  REQ_BYTE_EN_WIDTH  element-enable bits
- vid_addr  out  REQ_ADDR_WIDTH  beat address
- vid_resp_valid  in  1  datapath result retired
- busy  out  1  state != IDLE
- done  out  1  one-cycle completion pulse
- req_err  out  1  one-cycle pulse, illegal SEW
- req_abort  in  1  present only with VID_SEQ_ABORT_EN

## Operation
- The FSM has three states: IDLE, ISSUE and DRAIN.
- **Accept:** a handshake is `req_valid && req_ready`. On accept the block latches vl, sew and addr, and clears `beat_idx`, `elem_idx` and `in_flight`.
- **Accept transition:**
  - sew > 3: stay IDLE; assert `req_err` and `done` in the next cycle; no beats issued.
  - vl == 0: stay IDLE; assert `done` in the next cycle; no beats issued.
  - otherwise: go to ISSUE.
- **ISSUE:**
  - Issue one beat per cycle; `vid_valid` = 1.
  - epb = REQ_BYTE_EN_WIDTH >> sew.
  - `vid_start_idx` = `elem_idx[7:0]`.
  - `vid_mask` = low min(vl − elem_idx, epb) bits set; all other bits 0.
  - `vid_addr` = base + beat_idx.
  - After each beat, `elem_idx += epb` and `beat_idx += 1`.
  - After the beat that makes `elem_idx >= vl`, go to DRAIN.
- **In-flight counter:** width $clog2(PIPE_LAT+1)+1.
  - +1 per issued beat, −1 per `vid_resp_valid`.
  - Both in the same cycle: no change.
  - `vid_resp_valid` while the count is 0 is ignored; the count stays 0.
- **DRAIN:**
  - `vid_valid` = 0.
  - When the count reaches 0 after a decrement, pulse `done` in the next cycle and return to IDLE.
- **Idle outputs:** outside ISSUE, `vid_start_idx`, `vid_mask` and `vid_addr` are 0; `vid_sew` holds the last latched value.
- **Reset:** `rst` mid-operation returns to IDLE and clears all counters; the datapath is reset on the same `rst`.
- **Reset values:** `req_ready` = 1; `vid_valid`, `vid_sew`, `vid_start_idx`, `vid_mask`, `vid_addr`, `busy`, `done`, `req_err` = 0.

## Timing
- All outputs are registered, except that `req_ready` is decoded from the state register.
- Accept on edge T; first `vid_valid` in cycle T+1.
- N beats occupy cycles T+1..T+N with no bubbles.
- `vid_resp_valid` for beat k arrives in cycle T+k+PIPE_LAT.
- `done` is high in the cycle after the final response: cycle T+N+PIPE_LAT+1.
- `req_ready` rises in that same `done` cycle, so a back-to-back accept is possible then.
- Illegal-SEW and vl=0 requests: `done` at T+1, with `req_ready` staying high.
- Beat count N = ceil(vl / epb). `elem_idx` uses VL_WIDTH bits; `vid_start_idx` is only its low 8 bits, with max index 255.

## Configuration
- Macro: `VID_SEQ_ABORT_EN`.
- **Defined:** adds port `req_abort`.
  - `req_abort` high in ISSUE: no further beats; go to DRAIN on the next edge.
  - The beat issued in the cycle `req_abort` is sampled still counts.
  - `req_abort` is ignored in IDLE and DRAIN.
  - `done` still waits for `in_flight` to reach 0.
- **Undefined:** no port; every accepted request issues all N beats.

## Test plan
- vl=8, sew=0, addr=0x100: one beat with idx 0, mask 0xFF, addr 0x100 at T+1 → `done` at T+8; `busy` high T+1..T+7.
- vl=13, sew=1: four beats; idx 0,4,8,12; masks 0x0F,0x0F,0x0F,0x01; addr base..base+3 → `done` at T+11.
- vl=0 and sew=5 requests: no `vid_valid`; `done` at T+1; `req_err` high at T+1 only for sew=5.
- vl=256, sew=3: 256 beats; last beat idx 255, mask 0x01 → `done` at T+263; no idx wrap before the last beat.
- `rst` asserted during ISSUE on beat 3 of 5: next cycle `vid_valid`=0, `busy`=0, `req_ready`=1; the following request runs cleanly from idx 0.
- With `VID_SEQ_ABORT_EN`: vl=32, sew=0, `req_abort` high in cycle T+2 → exactly 2 beats issued; `done` at T+2+PIPE_LAT+1 = T+9.
